// File: rtl/rv32i_ex_mem_stage.sv
// EX->MEM pipeline register: resolves branches/jumps into a one-cycle redirect and
// holds one EX/MEM entry for the memory stage. Optional: RV32I_MISALIGN_TRAP_EN.
module rv32i_ex_mem_stage #(
  parameter int XLEN_P = 32,
  parameter int REGA_P = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN_P-1:0] ex_pc_i,
  input  logic [XLEN_P-1:0] ex_imm_i,
  input  logic [XLEN_P-1:0] alu_result_i,
  input  logic              cmp_eq_i,
  input  logic              cmp_lt_i,
  input  logic              cmp_ltu_i,
  input  logic              is_branch_i,
  input  logic              is_jal_i,
  input  logic              is_jalr_i,
  input  logic [2:0]        funct3_i,
  input  logic [REGA_P-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [XLEN_P-1:0] store_data_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [XLEN_P-1:0] mem_result_o,
  output logic [XLEN_P-1:0] mem_addr_o,
  output logic [XLEN_P-1:0] mem_store_data_o,
  output logic [2:0]        mem_funct3_o,
  output logic [REGA_P-1:0] mem_rd_addr_o,
  output logic              mem_rd_we_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic              redirect_o,
`ifdef RV32I_MISALIGN_TRAP_EN
  output logic              trap_o,
`endif
  output logic [XLEN_P-1:0] redirect_pc_o
);

  // Handshake: an EX transfer happens when ex_valid_i && ex_ready_o && !flush_i;
  // a MEM transfer happens when mem_valid_o && mem_ready_i. Both may occur in one cycle.
  logic              valid_q;
  logic              redirect_q;
  logic [XLEN_P-1:0] redirect_pc_q;
  logic [XLEN_P-1:0] result_q;
  logic [XLEN_P-1:0] addr_q;
  logic [XLEN_P-1:0] store_data_q;
  logic [2:0]        funct3_q;
  logic [REGA_P-1:0] rd_addr_q;
  logic              rd_we_q;
  logic              mem_rd_q;
  logic              mem_wr_q;

  logic              accept;
  logic              cond;
  logic              taken;
  logic              suppress;
  logic [XLEN_P-1:0] target;
  logic [XLEN_P-1:0] link_pc;

  assign ex_ready_o = !valid_q || mem_ready_i;
  assign accept     = ex_valid_i && ex_ready_o && !flush_i;

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      3'b000:  cond = cmp_eq_i;
      3'b001:  cond = !cmp_eq_i;
      3'b100:  cond = cmp_lt_i;
      3'b101:  cond = !cmp_lt_i;
      3'b110:  cond = cmp_ltu_i;
      3'b111:  cond = !cmp_ltu_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken   = is_jal_i || is_jalr_i || (is_branch_i && cond);
  assign target  = is_jalr_i ? {alu_result_i[XLEN_P-1:1], 1'b0} : (ex_pc_i + ex_imm_i);
  assign link_pc = ex_pc_i + XLEN_P'(4);

`ifdef RV32I_MISALIGN_TRAP_EN
  // A taken jump to a non-word-aligned target traps instead of redirecting and retires no side effects.
  assign suppress = taken && target[1];
  logic trap_q;
  assign trap_o = trap_q;
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      result_q      <= '0;
      addr_q        <= '0;
      store_data_q  <= '0;
      funct3_q      <= '0;
      rd_addr_q     <= '0;
      rd_we_q       <= 1'b0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
`ifdef RV32I_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else if (flush_i) begin
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
`ifdef RV32I_MISALIGN_TRAP_EN
      trap_q     <= 1'b0;
`endif
    end else begin
      redirect_q <= accept && taken && !suppress;
`ifdef RV32I_MISALIGN_TRAP_EN
      trap_q     <= accept && suppress;
`endif
      if (accept) begin
        valid_q      <= 1'b1;
        result_q     <= (is_jal_i || is_jalr_i) ? link_pc : alu_result_i;
        addr_q       <= alu_result_i;
        store_data_q <= store_data_i;
        funct3_q     <= funct3_i;
        rd_addr_q    <= rd_addr_i;
        rd_we_q      <= rd_we_i && (rd_addr_i != '0) && !suppress;
        mem_rd_q     <= mem_rd_i && !suppress;
        mem_wr_q     <= mem_wr_i && !suppress;
        if (taken && !suppress) redirect_pc_q <= target;
      end else if (mem_ready_i && valid_q) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign mem_valid_o      = valid_q;
  assign mem_result_o     = result_q;
  assign mem_addr_o       = addr_q;
  assign mem_store_data_o = store_data_q;
  assign mem_funct3_o     = funct3_q;
  assign mem_rd_addr_o    = rd_addr_q;
  assign mem_rd_we_o      = rd_we_q;
  assign mem_rd_o         = mem_rd_q;
  assign mem_wr_o         = mem_wr_q;
  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule

// File: tb/tb_rv32i_ex_mem_stage.sv
// Bench for rv32i_ex_mem_stage: directed cases with literal expectations plus random
// traffic compared every cycle against a transaction-level model.
module tb_rv32i_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, ex_valid, ex_ready, cmp_eq, cmp_lt, cmp_ltu;
  logic        is_branch, is_jal, is_jalr, rd_we, mem_rd, mem_wr, mem_ready;
  logic [31:0] ex_pc, ex_imm, alu_result, store_data;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr;
  logic        mem_valid, mem_rd_we, mem_rd_en, mem_wr_en, redirect;
  logic [31:0] mem_result, mem_addr, mem_store_data, redirect_pc;
  logic [2:0]  mem_funct3;
  logic [4:0]  mem_rd_addr;
`ifdef RV32I_MISALIGN_TRAP_EN
  logic        trap;
`endif

  int checks = 0;
  int errors = 0;
  bit checking_on = 0;

  rv32i_ex_mem_stage #(.XLEN_P(32), .REGA_P(5)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .alu_result_i(alu_result),
    .cmp_eq_i(cmp_eq), .cmp_lt_i(cmp_lt), .cmp_ltu_i(cmp_ltu),
    .is_branch_i(is_branch), .is_jal_i(is_jal), .is_jalr_i(is_jalr), .funct3_i(funct3),
    .rd_addr_i(rd_addr), .rd_we_i(rd_we), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
    .store_data_i(store_data), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_result_o(mem_result), .mem_addr_o(mem_addr), .mem_store_data_o(mem_store_data),
    .mem_funct3_o(mem_funct3), .mem_rd_addr_o(mem_rd_addr), .mem_rd_we_o(mem_rd_we),
    .mem_rd_o(mem_rd_en), .mem_wr_o(mem_wr_en), .redirect_o(redirect),
`ifdef RV32I_MISALIGN_TRAP_EN
    .trap_o(trap),
`endif
    .redirect_pc_o(redirect_pc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    ex_valid = 0; flush = 0; ex_pc = 0; ex_imm = 0; alu_result = 0;
    cmp_eq = 0; cmp_lt = 0; cmp_ltu = 0; is_branch = 0; is_jal = 0; is_jalr = 0;
    funct3 = 0; rd_addr = 0; rd_we = 0; mem_rd = 0; mem_wr = 0; store_data = 0;
  endtask

  // kind: 0 ALU/mem, 1 branch, 2 JAL, 3 JALR
  task automatic drive_op(input int kind, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] alu, input logic [2:0] f3, input logic [2:0] flags,
                          input logic [4:0] rd, input logic we);
    ex_valid = 1; ex_pc = pc; ex_imm = imm; alu_result = alu; funct3 = f3;
    {cmp_eq, cmp_lt, cmp_ltu} = flags;
    is_branch = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
    rd_addr = rd; rd_we = we; mem_rd = 0; mem_wr = 0; store_data = 32'h5A5A_0000 ^ alu;
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  typedef struct packed {
    logic [31:0] result, addr, sdata;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rd_we, rd_en, wr_en;
  } entry_t;

  entry_t      exp_q[$];
  logic        exp_redirect = 0;
  logic        exp_trap = 0;
  logic [31:0] exp_redirect_pc = 0;

  function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic        acc, tk, mis, jump;
    logic [31:0] tgt;
    entry_t      e;
    if (rst) begin
      exp_q.delete();
      exp_redirect = 0;
      exp_trap = 0;
      exp_redirect_pc = 0;
    end else if (flush) begin
      exp_q.delete();
      exp_redirect = 0;
      exp_trap = 0;
    end else begin
      acc  = ex_valid && (exp_q.size() == 0 || mem_ready);
      jump = is_jal || is_jalr;
      tk   = jump || (is_branch && branch_cond(funct3, cmp_eq, cmp_lt, cmp_ltu));
      tgt  = is_jalr ? (alu_result & 32'hFFFF_FFFE) : ex_pc + ex_imm;
`ifdef RV32I_MISALIGN_TRAP_EN
      mis  = tk && tgt[1];
`else
      mis  = 1'b0;
`endif
      if (exp_q.size() != 0 && mem_ready) void'(exp_q.pop_front());
      if (acc) begin
        e.result = jump ? ex_pc + 32'd4 : alu_result;
        e.addr   = alu_result;
        e.sdata  = store_data;
        e.f3     = funct3;
        e.rd     = rd_addr;
        e.rd_we  = rd_we && rd_addr != 0 && !mis;
        e.rd_en  = mem_rd && !mis;
        e.wr_en  = mem_wr && !mis;
        exp_q.push_back(e);
        if (tk && !mis) exp_redirect_pc = tgt;
      end
      exp_redirect = acc && tk && !mis;
      exp_trap     = acc && mis;
    end
  end

  // Compare process: every cycle once out of initial reset.
  always @(negedge clk) begin
    if (checking_on) begin
      check("ex_ready", {31'd0, ex_ready}, {31'd0, exp_q.size() == 0 || mem_ready});
      check("mem_valid", {31'd0, mem_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("mem_result", mem_result, exp_q[0].result);
        check("mem_addr", mem_addr, exp_q[0].addr);
        check("mem_store_data", mem_store_data, exp_q[0].sdata);
        check("mem_funct3", {29'd0, mem_funct3}, {29'd0, exp_q[0].f3});
        check("mem_rd_addr", {27'd0, mem_rd_addr}, {27'd0, exp_q[0].rd});
        check("mem_ctl", {29'd0, mem_rd_we, mem_rd_en, mem_wr_en},
              {29'd0, exp_q[0].rd_we, exp_q[0].rd_en, exp_q[0].wr_en});
      end
      check("redirect", {31'd0, redirect}, {31'd0, exp_redirect});
      if (exp_redirect) check("redirect_pc", redirect_pc, exp_redirect_pc);
`ifdef RV32I_MISALIGN_TRAP_EN
      check("trap", {31'd0, trap}, {31'd0, exp_trap});
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    mem_ready = 1;
    rst = 1;
    repeat (3) tick();
    // Reset state
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst ex_ready", {31'd0, ex_ready}, 32'd1);
    check("rst redirect", {31'd0, redirect}, 32'd0);
    check("rst redirect_pc", redirect_pc, 32'd0);
    check("rst mem_result", mem_result, 32'd0);
    check("rst mem_rd_we", {31'd0, mem_rd_we}, 32'd0);
    rst = 0;
    checking_on = 1;

    // BEQ taken
    drive_op(1, 32'h100, 32'h20, 32'h0, 3'b000, 3'b100, 5'd0, 1'b0);
    tick();
    check("beq redirect", {31'd0, redirect}, 32'd1);
    check("beq redirect_pc", redirect_pc, 32'h120);
    check("beq mem_valid", {31'd0, mem_valid}, 32'd1);

    // JALR clears bit 0 of the target and links pc+4
    drive_op(3, 32'h40, 32'h0, 32'h2003, 3'b000, 3'b000, 5'd1, 1'b1);
    tick();
    check("jalr redirect", {31'd0, redirect}, 32'd1);
    check("jalr redirect_pc", redirect_pc, 32'h2002);
    check("jalr mem_result", mem_result, 32'h44);
    check("jalr mem_rd_we", {31'd0, mem_rd_we}, 32'd1);

    // Stall: hold ADD A, keep ADD B waiting for three cycles
    drive_idle();
    tick();
    mem_ready = 0;
    drive_op(0, 32'h200, 32'h0, 32'h11, 3'b000, 3'b000, 5'd3, 1'b1);
    tick();
    check("add_a result", mem_result, 32'h11);
    drive_op(0, 32'h204, 32'h0, 32'h22, 3'b000, 3'b000, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall ex_ready", {31'd0, ex_ready}, 32'd0);
      check("stall result", mem_result, 32'h11);
      check("stall rd_addr", {27'd0, mem_rd_addr}, 32'd3);
    end
    mem_ready = 1;
    tick();
    check("add_b result", mem_result, 32'h22);
    check("add_b valid", {31'd0, mem_valid}, 32'd1);
    drive_idle();
    tick();
    check("drained valid", {31'd0, mem_valid}, 32'd0);

    // BNE taken with flush in the same cycle
    drive_op(1, 32'h300, 32'h40, 32'h0, 3'b001, 3'b000, 5'd0, 1'b0);
    flush = 1;
    tick();
    check("flush redirect", {31'd0, redirect}, 32'd0);
    check("flush mem_valid", {31'd0, mem_valid}, 32'd0);
    flush = 0;

    // JAL wrapping past the top of the address space
    drive_op(2, 32'hFFFF_FFFC, 32'h8, 32'h0, 3'b000, 3'b000, 5'd1, 1'b1);
    tick();
    check("jal wrap redirect_pc", redirect_pc, 32'h4);
    check("jal wrap mem_result", mem_result, 32'h0);

    // Write to x0 never enables rd_we
    drive_op(0, 32'h0, 32'h0, 32'h77, 3'b000, 3'b000, 5'd0, 1'b1);
    tick();
    check("x0 rd_we", {31'd0, mem_rd_we}, 32'd0);

`ifdef RV32I_MISALIGN_TRAP_EN
    drive_op(2, 32'h0, 32'h6, 32'h0, 3'b000, 3'b000, 5'd1, 1'b1);
    tick();
    check("mis trap", {31'd0, trap}, 32'd1);
    check("mis redirect", {31'd0, redirect}, 32'd0);
    check("mis rd_we", {31'd0, mem_rd_we}, 32'd0);
`endif

    // Mid-operation reset drops a stalled entry
    mem_ready = 0;
    drive_op(0, 32'h0, 32'h0, 32'h99, 3'b000, 3'b000, 5'd2, 1'b1);
    tick();
    drive_idle();
    rst = 1;
    tick();
    rst = 0;
    check("midrst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("midrst ex_ready", {31'd0, ex_ready}, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      int kind;
      kind = $urandom_range(0, 3);
      pc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FF00 | ($urandom_range(0, 63) << 2) : $urandom;
      if ($urandom_range(0, 3) != 0)
        drive_op(kind, pc, $urandom, $urandom, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else
        drive_idle();
      mem_rd = 1'($urandom_range(0, 1));
      mem_wr = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    drive_idle();
    rst = 0;
    mem_ready = 1;
    repeat (3) tick();
    checking_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
